// File: rtl/fft_pkg.sv
// Shared constants, sample type and index helpers for the 16-point FFT input stage.
package fft_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned N_POINTS = 16;
    localparam int unsigned LOG2_N   = $clog2(N_POINTS);

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } complex_t;

    typedef enum logic {
        StFill,
        StHold
    } bank_state_e;

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] idx);
        logic [LOG2_N-1:0] r;
        for (int unsigned i = 0; i < LOG2_N; i++) begin
            r[i] = idx[LOG2_N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_bank.sv
// One frame of complex samples: single write port, every slot read out in parallel.
module fft_sample_bank
    import fft_pkg::*;
(
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       we,
    input  logic [LOG2_N-1:0]          waddr,
    input  complex_t                   wdata,
    output logic [N_POINTS*DATA_W-1:0] rd_real,
    output logic [N_POINTS*DATA_W-1:0] rd_imag
);

    complex_t mem_q [N_POINTS];
    complex_t mem_d [N_POINTS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < N_POINTS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_real = '0;
        rd_imag = '0;
        for (int unsigned i = 0; i < N_POINTS; i++) begin
            rd_real[DATA_W*i +: DATA_W] = mem_q[i].re;
            rd_imag[DATA_W*i +: DATA_W] = mem_q[i].im;
        end
    end

endmodule

// File: rtl/fft_sample_loader.sv
// Serial-to-parallel loader storing samples at bit-reversed slots.
// Define FFT_LOADER_PINGPONG_EN for two banks (fill one while the other is held).
module fft_sample_loader #(
    parameter int unsigned DATA_W   = fft_pkg::DATA_W,
    parameter int unsigned N_POINTS = fft_pkg::N_POINTS
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_real,
    input  logic [DATA_W-1:0]          in_imag,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [N_POINTS*DATA_W-1:0] frame_real,
    output logic [N_POINTS*DATA_W-1:0] frame_imag,
    output logic [7:0]                 frame_count
);

    localparam int unsigned LOG2_N = $clog2(N_POINTS);
`ifdef FFT_LOADER_PINGPONG_EN
    localparam int unsigned NBanks = 2;
`else
    localparam int unsigned NBanks = 1;
`endif

    fft_pkg::bank_state_e state_q [NBanks];
    fft_pkg::bank_state_e state_d [NBanks];
    logic [LOG2_N-1:0]    wr_idx_q, wr_idx_d;
    logic [7:0]           count_q, count_d;
    logic                 accept, take;
    logic [NBanks-1:0]    bank_we;
    logic [LOG2_N-1:0]    waddr;
    fft_pkg::complex_t    wdata;
    logic [N_POINTS*DATA_W-1:0] bank_real [NBanks];
    logic [N_POINTS*DATA_W-1:0] bank_imag [NBanks];

`ifdef FFT_LOADER_PINGPONG_EN
    logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;

    assign in_ready    = (state_q[wr_bank_q] == fft_pkg::StFill);
    assign frame_valid = (state_q[rd_bank_q] == fft_pkg::StHold);
    assign frame_real  = bank_real[rd_bank_q];
    assign frame_imag  = bank_imag[rd_bank_q];
    assign bank_we     = {accept && wr_bank_q, accept && !wr_bank_q};
`else
    assign in_ready    = (state_q[0] == fft_pkg::StFill);
    assign frame_valid = (state_q[0] == fft_pkg::StHold);
    assign frame_real  = bank_real[0];
    assign frame_imag  = bank_imag[0];
    assign bank_we     = accept;
`endif

    assign accept      = in_valid && in_ready;
    assign take        = frame_valid && frame_ready;
    assign waddr       = fft_pkg::bitrev(wr_idx_q);
    assign wdata       = '{re: in_real, im: in_imag};
    assign frame_count = count_q;

    // A write bank and the read bank are never the same bank in the same state,
    // so accept and take can both update state_d without colliding.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        count_d  = count_q;
`ifdef FFT_LOADER_PINGPONG_EN
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
`endif
        if (flush) begin
            for (int unsigned b = 0; b < NBanks; b++) begin
                state_d[b] = fft_pkg::StFill;
            end
            wr_idx_d = '0;
`ifdef FFT_LOADER_PINGPONG_EN
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
`endif
        end else begin
            if (accept) begin
                wr_idx_d = wr_idx_q + 1'b1;
                // N_POINTS is a power of two, so all-ones marks the last slot.
                if (&wr_idx_q) begin
`ifdef FFT_LOADER_PINGPONG_EN
                    state_d[wr_bank_q] = fft_pkg::StHold;
                    wr_bank_d          = ~wr_bank_q;
`else
                    state_d[0] = fft_pkg::StHold;
`endif
                end
            end
            if (take) begin
                count_d = count_q + 8'd1;
`ifdef FFT_LOADER_PINGPONG_EN
                state_d[rd_bank_q] = fft_pkg::StFill;
                rd_bank_d          = ~rd_bank_q;
`else
                state_d[0] = fft_pkg::StFill;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned b = 0; b < NBanks; b++) begin
                state_q[b] <= fft_pkg::StFill;
            end
            wr_idx_q <= '0;
            count_q  <= '0;
`ifdef FFT_LOADER_PINGPONG_EN
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            count_q  <= count_d;
`ifdef FFT_LOADER_PINGPONG_EN
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
`endif
        end
    end

    for (genvar b = 0; b < NBanks; b++) begin : g_bank
        fft_sample_bank u_bank (
            .clk     (clk),
            .n_rst   (n_rst),
            .we      (bank_we[b]),
            .waddr   (waddr),
            .wdata   (wdata),
            .rd_real (bank_real[b]),
            .rd_imag (bank_imag[b])
        );
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader: bit-reversed frames, handshake, flush and reset.
module tb_fft_sample_loader;

    localparam int W = 16;
    localparam int N = 16;
`ifdef FFT_LOADER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           n_rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_real;
    logic [W-1:0]   in_imag;
    logic           frame_valid;
    logic           frame_ready;
    logic [N*W-1:0] frame_real;
    logic [N*W-1:0] frame_imag;
    logic [7:0]     frame_count;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fft_sample_loader dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_real  (frame_real),
        .frame_imag  (frame_imag),
        .frame_count (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rev4(input int k);
        logic [3:0] v;
        v = k[3:0];
        return int'({v[0], v[1], v[2], v[3]});
    endfunction

    function automatic logic [31:0] slot_re(input int k);
        return 32'(frame_real[W*k +: W]);
    endfunction

    function automatic logic [31:0] slot_im(input int k);
        return 32'(frame_imag[W*k +: W]);
    endfunction

    task automatic check_frame(input string tag, input int rbase, input int ibase);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_re%0d", tag, k), slot_re(k), 32'(rbase + rev4(k)));
            check($sformatf("%s_im%0d", tag, k), slot_im(k), 32'(ibase + rev4(k)));
        end
    endtask

    task automatic push(input int re, input int im);
        in_real  = W'(re);
        in_imag  = W'(im);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic feed(input int rbase, input int ibase, input int first, input bit gaps);
        for (int n = first; n < N; n++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            check("fill_ready", 32'(in_ready), 32'd1);
            push(rbase + n, ibase + n);
        end
    endtask

    task automatic handshake();
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        n_rst       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        frame_ready = 1'b0;
        in_real     = '0;
        in_imag     = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        check("rst_real", 32'(|frame_real), 32'd0);
        check("rst_imag", 32'(|frame_imag), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Frame of x[n] = (n, 100+n), consumer not ready.
        feed(0, 100, 0, 1'b0);
        check("f0_valid", 32'(frame_valid), 32'd1);
        check("f0_in_ready", 32'(in_ready), PP ? 32'd1 : 32'd0);
        check("f0_slot0_re", slot_re(0), 32'd0);
        check("f0_slot0_im", slot_im(0), 32'd100);
        check("f0_slot1_re", slot_re(1), 32'd8);
        check("f0_slot1_im", slot_im(1), 32'd108);
        check("f0_slot3_re", slot_re(3), 32'd12);
        check("f0_slot3_im", slot_im(3), 32'd112);
        check("f0_slot15_re", slot_re(15), 32'd15);
        check("f0_slot15_im", slot_im(15), 32'd115);
        check_frame("f0", 0, 100);

        // Held frame stays stable while the consumer stalls.
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(frame_valid), 32'd1);
            check("hold_slot1", slot_re(1), 32'd8);
            check("hold_slot6", slot_re(6), 32'd6);
        end

        // Sample offered during the handshake is refused (single bank) and taken next cycle.
        in_real     = W'(300);
        in_imag     = W'(400);
        in_valid    = !PP;
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        check("hs_valid_low", 32'(frame_valid), 32'd0);
        check("hs_count", 32'(frame_count), 32'd1);
        check("hs_in_ready", 32'(in_ready), 32'd1);
        push(300, 400);
        feed(300, 400, 1, 1'b1);
        check("f1_valid", 32'(frame_valid), 32'd1);
        check_frame("f1", 300, 400);
        handshake();

        // Two more frames with random input gaps.
        feed(1000, 1100, 0, 1'b1);
        check("f2_valid", 32'(frame_valid), 32'd1);
        check_frame("f2", 1000, 1100);
        handshake();
        feed(2000, 2100, 0, 1'b1);
        check("f3_valid", 32'(frame_valid), 32'd1);
        check_frame("f3", 2000, 2100);
        handshake();
        check("count_after_gaps", 32'(frame_count), 32'd4);

        // Flush mid-frame, then a fresh frame of 200+n.
        for (int n = 0; n < 7; n++) push(500 + n, 600 + n);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_valid", 32'(frame_valid), 32'd0);
        check("flush_count", 32'(frame_count), 32'd4);
        feed(200, 300, 0, 1'b0);
        check("ff_valid", 32'(frame_valid), 32'd1);
        check("ff_slot1_re", slot_re(1), 32'd208);
        check_frame("ff", 200, 300);

        // Flush beats a simultaneous handshake on a held frame.
        flush       = 1'b1;
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        frame_ready = 1'b0;
        check("flush_hold_valid", 32'(frame_valid), 32'd0);
        check("flush_hold_count", 32'(frame_count), 32'd4);
        check("flush_hold_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-frame.
        for (int n = 0; n < 9; n++) push(700 + n, 800 + n);
        n_rst = 1'b0;
        #2;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_valid", 32'(frame_valid), 32'd0);
        check("arst_count", 32'(frame_count), 32'd0);
        check("arst_real", 32'(|frame_real), 32'd0);
        check("arst_imag", 32'(|frame_imag), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        feed(40, 140, 0, 1'b0);
        check("ar_valid", 32'(frame_valid), 32'd1);
        check_frame("ar", 40, 140);
        handshake();
        check("ar_count", 32'(frame_count), 32'd1);

`ifdef FFT_LOADER_PINGPONG_EN
        // Continuous stream into two banks with an always-ready consumer.
        frame_ready = 1'b1;
        for (int n = 0; n < 4 * N; n++) begin
            push(900 + n, 1000 + n);
            check("pp_in_ready", 32'(in_ready), 32'd1);
            if (n % N == N - 1) begin
                check("pp_valid", 32'(frame_valid), 32'd1);
                check("pp_slot1", slot_re(1), 32'(900 + (n / N) * N + 8));
            end
        end
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        check("pp_count", 32'(frame_count), 32'd5);
        check("pp_valid_end", 32'(frame_valid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
